// File: rtl/cla_wide_add_seq.sv
// cla_wide_add_seq: splits one W-bit add into W/N slices, LSB first, feeds them
// through an N-bit registered carry-lookahead adder, chains the slice carries and
// returns the W-bit sum plus final carry on a valid/ready output.
// cla_adder_reg: the N-bit registered CLA slice adder the sequencer drives.

module cla_adder_reg #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  // Carries are resolved in 4-bit lookahead groups.
  localparam int NG = N / 4;

  generate
    if ((N % 4) != 0 || N < 4) begin : g_bad_n
      $error("cla_adder_reg: N must be a positive multiple of 4");
    end
  endgenerate

  logic [N-1:0]  p;
  logic [N-1:0]  g;
  logic [N-1:0]  c;
  logic [NG-1:0] grp_p;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_cin;
  logic          carry_out;

  assign p = A ^ B;
  assign g = A & B;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      localparam int B0 = gi * 4;
      // Group propagate/generate for the inter-group lookahead.
      assign grp_p[gi] = p[B0+3] & p[B0+2] & p[B0+1] & p[B0];
      assign grp_g[gi] = g[B0+3]
                       | (p[B0+3] & g[B0+2])
                       | (p[B0+3] & p[B0+2] & g[B0+1])
                       | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
      // Bit carries inside the group, all expressed from the group carry-in.
      assign c[B0]   = grp_cin[gi];
      assign c[B0+1] = g[B0] | (p[B0] & grp_cin[gi]);
      assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0])
                     | (p[B0+1] & p[B0] & grp_cin[gi]);
      assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1])
                     | (p[B0+2] & p[B0+1] & g[B0])
                     | (p[B0+2] & p[B0+1] & p[B0] & grp_cin[gi]);
    end
  endgenerate

  // Group carry chain from the slice carry-in using group generate/propagate.
  always_comb begin
    logic carry;
    carry   = Cin;
    grp_cin = '0;
    for (int i = 0; i < NG; i++) begin
      grp_cin[i] = carry;
      carry      = grp_g[i] | (grp_p[i] & carry);
    end
    carry_out = carry;
  end

  // Register sum and carry-out: one cycle of latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Sum  <= '0;
      Cout <= 1'b0;
    end else begin
      Sum  <= p ^ c;
      Cout <= carry_out;
    end
  end

endmodule

module cla_wide_add_seq #(
  parameter int N = 16,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
);

  localparam int S  = W / N;
  // Counters must hold 0..S (issue counter reaches S once all slices are out).
  localparam int CW = (S < 1) ? 1 : $clog2(S + 1);

  generate
    if ((W % N) != 0 || W < N) begin : g_bad_w
      $error("cla_wide_add_seq: W must be a non-zero multiple of N");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic [CW-1:0] issue_q, issue_d;
  logic [CW-1:0] cap_q, cap_d;

  logic          issuing;
  logic          capturing;
  logic [N-1:0]  a_slice [S];
  logic [N-1:0]  b_slice [S];

  genvar gi;
  generate
    for (gi = 0; gi < S; gi++) begin : g_slice
      assign a_slice[gi] = a_q[gi*N +: N];
      assign b_slice[gi] = b_q[gi*N +: N];
    end
  endgenerate

  // A slice is issued while the issue counter is below S; captures trail by one.
  assign issuing   = (state_q == ST_RUN) && (issue_q < CW'(S));
  assign capturing = (state_q == ST_RUN) && (issue_q != '0);

  // State, latched operands, collected result and both counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      issue_q <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      issue_q <= issue_d;
      cap_q   <= cap_d;
    end
  end

  // Next state, operand latch, counters and final carry capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    cout_d  = cout_q;
    issue_d = issue_q;
    cap_d   = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          issue_d = '0;
          cap_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issuing) begin
          issue_d = issue_q + CW'(1);
        end
        if (capturing) begin
          cap_d = cap_q + CW'(1);
          if (cap_q == CW'(S - 1)) begin
            cout_d  = add_cout;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Slice mux toward the adder; the carry of slices above 0 comes straight from add_cout.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (issuing) begin
      for (int i = 0; i < S; i++) begin
        if (issue_q == CW'(i)) begin
          add_a = a_slice[i];
          add_b = b_slice[i];
        end
      end
      add_cin = (issue_q == '0) ? cin_q : add_cout;
    end
  end

  // Write the returning adder slice into its place in the collected sum.
  always_comb begin
    sum_d = sum_q;
    if (capturing) begin
      for (int i = 0; i < S; i++) begin
        if (cap_q == CW'(i)) begin
          sum_d[i*N +: N] = add_sum;
        end
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule
